// File: rtl/bm_dag2_pkg.sv
// Shared constants and capture word type for the two-bit DAG microbenchmark.
// Optional parity bit in the capture word: BM_DAG2_CAPTURE_PARITY_EN.
package bm_dag2_pkg;
  localparam int BITS        = 2;
  localparam int LATENCY_DEF = 3;
  localparam int DEPTH_DEF   = 4;

`ifdef BM_DAG2_CAPTURE_PARITY_EN
  localparam int CAP_W = BITS + 2;
`else
  localparam int CAP_W = BITS + 1;
`endif

  // {parity (optional), res1, res0}
  typedef logic [CAP_W-1:0] cap_word_t;
endpackage

// File: rtl/bm_dag2_capture_if.sv
// Producer/sink bundle for the DAG result-capture stage.
// Word width follows BM_DAG2_CAPTURE_PARITY_EN through cap_word_t.
interface bm_dag2_capture_if #(
  parameter int DEPTH = bm_dag2_pkg::DEPTH_DEF
);
  import bm_dag2_pkg::*;

  logic                         in_valid;
  logic [BITS-1:0]              res0_in;
  logic                         res1_in;
  logic                         out_valid;
  logic                         out_ready;
  cap_word_t                    out_data;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;

  modport master (
    output in_valid, res0_in, res1_in, out_ready,
    input  out_valid, out_data, count, overflow
  );

  modport slave (
    input  in_valid, res0_in, res1_in, out_ready,
    output out_valid, out_data, count, overflow
  );
endinterface

// File: rtl/bm_dag2_capture_fifo.sv
// First-word-fall-through FIFO holding aligned capture words.
// Word width follows BM_DAG2_CAPTURE_PARITY_EN through cap_word_t.
module bm_dag2_capture_fifo
  import bm_dag2_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_push,
  input  cap_word_t     i_word,
  input  logic          i_pop,
  output cap_word_t     o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = $clog2(DEPTH);

  cap_word_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_word;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/bm_dag2_capture.sv
// Realigns the DAG result pair with a tracked launch strobe and buffers it.
// Optional even-parity MSB on each stored word: BM_DAG2_CAPTURE_PARITY_EN.
module bm_dag2_capture
  import bm_dag2_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  bm_dag2_capture_if.slave   bus
);
  localparam int CW = $clog2(DEPTH+1);

  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-2:0] r_res1;
  logic               r_overflow;
  logic               w_push;
  logic               w_res1_al;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  cap_word_t          w_word;
  cap_word_t          w_head;
  logic [CW-1:0]      w_count;

  // res1 leaves the DAG one cycle after launch, res0 LATENCY cycles after,
  // so res1 needs one stage fewer than the launch strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld  <= '0;
      r_res1 <= '0;
    end else begin
      r_vld[0]  <= bus.in_valid;
      r_res1[0] <= bus.res1_in;
      for (int i = 1; i < LATENCY; i++)     r_vld[i]  <= r_vld[i-1];
      for (int i = 1; i < LATENCY - 1; i++) r_res1[i] <= r_res1[i-1];
    end
  end

  assign w_push    = r_vld[LATENCY-1];
  assign w_res1_al = r_res1[LATENCY-2];

`ifdef BM_DAG2_CAPTURE_PARITY_EN
  assign w_word = {^{w_res1_al, bus.res0_in}, w_res1_al, bus.res0_in};
`else
  assign w_word = {w_res1_al, bus.res0_in};
`endif

  assign w_pop = ~w_empty & bus.out_ready;

  bm_dag2_capture_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_word  (w_word),
    .i_pop   (bus.out_ready),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                         r_overflow <= 1'b0;
    else if (w_push & w_full & ~w_pop)    r_overflow <= 1'b1;
  end

  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_head;
  assign bus.count     = w_count;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_bm_dag2_capture.sv
// Directed bench for bm_dag2_capture with a queue-based reference model.
// Parity checks are added when BM_DAG2_CAPTURE_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_bm_dag2_capture;
  import bm_dag2_pkg::*;

  localparam int LAT = LATENCY_DEF;
  localparam int DEP = DEPTH_DEF;
  localparam int HN  = 1024;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bm_dag2_capture_if #(.DEPTH(DEP)) bus ();

  bm_dag2_capture #(
    .LATENCY (LAT),
    .DEPTH   (DEP)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int pops  = 0;

  // Input history per cycle; a launch at cycle t pushes {res1[t+1], res0[t+LAT]}
  // at the end of cycle t+LAT.
  bit              vh  [HN];
  bit              r1h [HN];
  logic [BITS-1:0] r0h [HN];
  bit              s_r1 [HN];
  logic [BITS-1:0] s_r0 [HN];
  cap_word_t       mq [$];
  bit              movf = 1'b0;

  function automatic cap_word_t exp_word(bit r1, logic [BITS-1:0] r0);
`ifdef BM_DAG2_CAPTURE_PARITY_EN
    return {^{r1, r0}, r1, r0};
`else
    return {r1, r0};
`endif
  endfunction

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endfunction

  always @(posedge clock) begin
    bit        push;
    bit        pop;
    cap_word_t w;
    if (!reset_n) begin
      mq.delete();
      movf    = 1'b0;
      vh[cyc] = 1'b0;
    end else begin
      vh[cyc]  = bus.in_valid;
      r1h[cyc] = bus.res1_in;
      r0h[cyc] = bus.res0_in;
      push = (cyc >= LAT) && vh[cyc-LAT];
      pop  = (mq.size() != 0) && bus.out_ready;
      w    = '0;
      if (push) w = exp_word(r1h[cyc-LAT+1], r0h[cyc]);
      if (pop) begin
        $display("pop  cyc=%0d word=%0h", cyc, mq[0]);
        void'(mq.pop_front());
        pops++;
      end
      if (push) begin
        if (mq.size() < DEP) begin
          mq.push_back(w);
          $display("push cyc=%0d word=%0h", cyc, w);
        end else begin
          movf = 1'b1;
          $display("drop cyc=%0d word=%0h", cyc, w);
        end
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      mq.delete();
      movf = 1'b0;
      for (int i = 0; i < HN; i++) vh[i] = 1'b0;
      chk("rst_out_data", int'(bus.out_data), 0);
    end
    chk("out_valid", int'(bus.out_valid), int'(mq.size() != 0));
    chk("count", int'(bus.count), mq.size());
    chk("overflow", int'(bus.overflow), int'(movf));
    if (mq.size() != 0) chk("out_data", int'(bus.out_data), int'(mq[0]));
  end

  task automatic step();
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.res1_in  = s_r1[cyc];
    bus.res0_in  = s_r0[cyc];
  endtask

  task automatic launch(bit r1, logic [BITS-1:0] r0);
    bus.in_valid     = 1'b1;
    s_r1[cyc+1]      = r1;
    s_r0[cyc+LAT]    = r0;
  endtask

  initial begin
    int p0;
    bus.in_valid  = 1'b0;
    bus.res1_in   = 1'b0;
    bus.res0_in   = '0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;
    repeat (2) step();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_ovf",   int'(bus.overflow), 0);
    chk("rst_data",  int'(bus.out_data), 0);
    step();
    reset_n = 1'b1;
    repeat (2) step();

    // single launch
    launch(1'b1, 2'b10);
    repeat (3) step();
    chk("single_early", int'(bus.out_valid), 0);
    step();
    chk("single_valid", int'(bus.out_valid), 1);
    chk("single_data",  int'(bus.out_data[BITS:0]), 3'b110);
    chk("single_count", int'(bus.count), 1);
    chk("model_single", int'(mq[0][BITS:0]), 3'b110);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("single_drain", int'(bus.count), 0);

    // streaming
    bus.out_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 6; i++) begin
      launch(1'(i % 2), BITS'(i % 4));
      step();
      chk("stream_cnt_le1", int'(bus.count <= 1), 1);
    end
    repeat (LAT + 2) begin
      step();
      chk("stream_cnt_le1", int'(bus.count <= 1), 1);
    end
    chk("stream_pops", pops - p0, 6);
    chk("stream_ovf", int'(bus.overflow), 0);
    bus.out_ready = 1'b0;

    // overflow
    for (int i = 0; i < 5; i++) begin
      launch(1'b1, BITS'(i % 4));
      step();
    end
    repeat (LAT + 1) step();
    chk("ovf_count", int'(bus.count), DEP);
    chk("ovf_flag",  int'(bus.overflow), 1);
    chk("ovf_head",  int'(bus.out_data[BITS:0]), 3'b100);
    chk("model_ovf", mq.size(), 4);
    bus.out_ready = 1'b1;
    repeat (4) step();
    bus.out_ready = 1'b0;
    chk("drain_count", int'(bus.count), 0);
    chk("drain_ovf",   int'(bus.overflow), 1);

    // full with simultaneous push and pop
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk("clr_ovf", int'(bus.overflow), 0);
    for (int i = 0; i < 4; i++) begin
      launch(1'b1, BITS'(i));
      step();
    end
    repeat (LAT) step();
    chk("full_count", int'(bus.count), DEP);
    launch(1'b0, 2'b10);
    repeat (LAT) step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("pp_count", int'(bus.count), DEP);
    chk("pp_ovf",   int'(bus.overflow), 0);
    chk("pp_head",  int'(bus.out_data[BITS:0]), 3'b101);
    bus.out_ready = 1'b1;
    repeat (3) step();
    bus.out_ready = 1'b0;
    chk("pp_tail", int'(bus.out_data[BITS:0]), 3'b010);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // reset mid-flight
    launch(1'b1, 2'b11);
    repeat (LAT + 1) step();
    chk("pre_rst_count", int'(bus.count), 1);
    launch(1'b1, 2'b01);
    repeat (2) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_data",  int'(bus.out_data), 0);
    step();
    chk("no_push_after_rst", int'(bus.count), 0);
    launch(1'b0, 2'b01);
    repeat (LAT + 1) step();
    chk("post_rst_valid", int'(bus.out_valid), 1);
    chk("post_rst_data",  int'(bus.out_data[BITS:0]), 3'b001);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

`ifdef BM_DAG2_CAPTURE_PARITY_EN
    launch(1'b1, 2'b11);
    step();
    launch(1'b0, 2'b01);
    step();
    repeat (LAT) step();
    chk("par_word0", int'(bus.out_data), 4'b1111);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("par_word1", int'(bus.out_data), 4'b1001);
`endif

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
